// File: rtl/systolic_nbody_pkg.sv
// Shared widths, schedule constants and the result-vector type for the 4-body force pass.
// Optional clamp-on-narrowing is selected with SYSTOLIC_ACC_SAT_EN.
package systolic_nbody_pkg;

    localparam int unsigned DATA_W       = 32;
    localparam int unsigned ACC_W        = DATA_W + 2;
    localparam int unsigned N_BODIES     = 4;
    localparam int unsigned EDGE_LOAD    = 2;
    localparam int unsigned EDGE_MID     = 3;
    localparam int unsigned EDGE_FINAL   = 4;
    localparam int unsigned EDGE_PUSH    = 5;
    localparam int unsigned CREDIT_DEPTH = 2;
    localparam int unsigned CREDIT_W     = 2;

    typedef struct packed {
        logic signed [DATA_W-1:0] a1;
        logic signed [DATA_W-1:0] a2;
        logic signed [DATA_W-1:0] a3;
        logic signed [DATA_W-1:0] a4;
    } acc_vec_t;

    // True when the wide sum does not fit a DATA_W signed word.
    function automatic logic acc_ovf(input logic [ACC_W-1:0] x);
        return !((&x[ACC_W-1:DATA_W-1]) || !(|x[ACC_W-1:DATA_W-1]));
    endfunction

    function automatic logic [DATA_W-1:0] acc_narrow(input logic [ACC_W-1:0] x);
`ifdef SYSTOLIC_ACC_SAT_EN
        if (acc_ovf(x)) begin
            return x[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
`endif
        return x[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/acc_vec_fifo.sv
// Two-entry FIFO of acceleration vectors; the head entry is a register so it drives outputs directly.
module acc_vec_fifo
    import systolic_nbody_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  acc_vec_t push_data,
    input  logic     pop,
    output acc_vec_t head,
    output logic     valid
);

    acc_vec_t ent0_q, ent0_d, ent1_q, ent1_d;
    logic     vld0_q, vld0_d, vld1_q, vld1_d;

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        vld0_d = vld0_q;
        vld1_d = vld1_q;
        if (pop && vld0_q) begin
            ent0_d = ent1_q;
            vld0_d = vld1_q;
            vld1_d = 1'b0;
        end
        // Push lands in the first slot left free after any pop.
        if (push) begin
            if (!vld0_d) begin
                ent0_d = push_data;
                vld0_d = 1'b1;
            end else begin
                ent1_d = push_data;
                vld1_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent0_q <= '0;
            ent1_q <= '0;
            vld0_q <= 1'b0;
            vld1_q <= 1'b0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            vld0_q <= vld0_d;
            vld1_q <= vld1_d;
        end
    end

    assign head  = ent0_q;
    assign valid = vld0_q;

endmodule

// File: rtl/systolic_2x2_force_accumulator.sv
// Folds systolic_2x2 right/down partials into per-body acceleration sums on a fixed token schedule.
// Define SYSTOLIC_ACC_SAT_EN to clamp on narrowing and enable the sticky sat_flag.
module systolic_2x2_force_accumulator
    import systolic_nbody_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     blk_start,
    output logic                     start_ready,
    input  logic signed [DATA_W-1:0] out_pr_0,
    input  logic signed [DATA_W-1:0] out_pr_1,
    input  logic signed [DATA_W-1:0] out_pd_0,
    input  logic signed [DATA_W-1:0] out_pd_1,
    output logic                     acc_valid,
    input  logic                     acc_ready,
    output logic signed [DATA_W-1:0] acc_1,
    output logic signed [DATA_W-1:0] acc_2,
    output logic signed [DATA_W-1:0] acc_3,
    output logic signed [DATA_W-1:0] acc_4,
    output logic                     sat_flag,
    output logic                     busy
);

    logic [EDGE_PUSH:1]       tok_q, tok_d;
    logic [CREDIT_W-1:0]      credits_q, credits_d;
    logic                     start_ready_q, start_ready_d;
    logic                     busy_q, busy_d;
    logic signed [ACC_W-1:0]  a1_q, a1_d, a2_q, a2_d, a3_q, a3_d, a4_q, a4_d;
    logic signed [ACC_W-1:0]  pr0_x, pr1_x, pd0_x, pd1_x, sum4;
    logic                     accept, push, pop, fifo_valid;
    acc_vec_t                 push_vec, head;

    assign pr0_x  = ACC_W'(out_pr_0);
    assign pr1_x  = ACC_W'(out_pr_1);
    assign pd0_x  = ACC_W'(out_pd_0);
    assign pd1_x  = ACC_W'(out_pd_1);
    assign accept = blk_start && start_ready_q;
    assign pop    = fifo_valid && acc_ready;

    // Schedule: stage k of a token acts at edge k after its accepted start.
    always_comb begin
        tok_d         = {tok_q[EDGE_PUSH-1:1], accept};
        a1_d          = a1_q;
        a2_d          = a2_q;
        a3_d          = a3_q;
        a4_d          = a4_q;
        credits_d     = credits_q;
        push          = tok_q[EDGE_PUSH];
        sum4          = a4_q + pr1_x;
        push_vec.a1   = acc_narrow(a1_q);
        push_vec.a2   = acc_narrow(a2_q);
        push_vec.a3   = acc_narrow(a3_q);
        push_vec.a4   = acc_narrow(sum4);

        if (tok_q[EDGE_LOAD]) begin
            a1_d = pr0_x;
        end
        if (tok_q[EDGE_MID]) begin
            a1_d = a1_q + pr0_x;
            a2_d = pr1_x;
            a3_d = pd0_x;
        end
        if (tok_q[EDGE_FINAL]) begin
            a2_d = a2_q + pr1_x;
            a3_d = a3_q + pr0_x;
            a4_d = pd1_x;
        end

        case ({accept, pop})
            2'b10:   credits_d = credits_q - CREDIT_W'(1);
            2'b01:   credits_d = credits_q + CREDIT_W'(1);
            default: credits_d = credits_q;
        endcase

        // Minimum start period of 3: block the two edges after any accepted start.
        start_ready_d = (credits_d != '0) && !accept && !tok_q[1];
        busy_d        = |tok_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tok_q         <= '0;
            credits_q     <= CREDIT_W'(CREDIT_DEPTH);
            start_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            a1_q          <= '0;
            a2_q          <= '0;
            a3_q          <= '0;
            a4_q          <= '0;
        end else begin
            tok_q         <= tok_d;
            credits_q     <= credits_d;
            start_ready_q <= start_ready_d;
            busy_q        <= busy_d;
            a1_q          <= a1_d;
            a2_q          <= a2_d;
            a3_q          <= a3_d;
            a4_q          <= a4_d;
        end
    end

`ifdef SYSTOLIC_ACC_SAT_EN
    logic sat_q, sat_d;

    always_comb begin
        sat_d = sat_q | (push && (acc_ovf(a1_q) | acc_ovf(a2_q) | acc_ovf(a3_q) | acc_ovf(sum4)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_flag = sat_q;
`else
    assign sat_flag = 1'b0;
`endif

    acc_vec_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_vec),
        .pop       (pop),
        .head      (head),
        .valid     (fifo_valid)
    );

    assign start_ready = start_ready_q;
    assign busy        = busy_q;
    assign acc_valid   = fifo_valid;
    assign acc_1       = head.a1;
    assign acc_2       = head.a2;
    assign acc_3       = head.a3;
    assign acc_4       = head.a4;

endmodule

// File: tb/tb_systolic_2x2_force_accumulator.sv
// Randomized bench for systolic_2x2_force_accumulator against a history-based reference model.
// Honors SYSTOLIC_ACC_SAT_EN for the expected narrowing behaviour.
module tb_systolic_2x2_force_accumulator;

    localparam int unsigned HIST = 8192;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        blk_start;
    logic        start_ready;
    logic [31:0] out_pr_0, out_pr_1, out_pd_0, out_pd_1;
    logic        acc_valid;
    logic        acc_ready;
    logic [31:0] acc_1, acc_2, acc_3, acc_4;
    logic        sat_flag;
    logic        busy;

    always #5 clk = ~clk;

    systolic_2x2_force_accumulator dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .blk_start   (blk_start),
        .start_ready (start_ready),
        .out_pr_0    (out_pr_0),
        .out_pr_1    (out_pr_1),
        .out_pd_0    (out_pd_0),
        .out_pd_1    (out_pd_1),
        .acc_valid   (acc_valid),
        .acc_ready   (acc_ready),
        .acc_1       (acc_1),
        .acc_2       (acc_2),
        .acc_3       (acc_3),
        .acc_4       (acc_4),
        .sat_flag    (sat_flag),
        .busy        (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: raw input history per edge, accepted start edges, expected result queue.
    logic signed [31:0] h_pr0 [HIST];
    logic signed [31:0] h_pr1 [HIST];
    logic signed [31:0] h_pd0 [HIST];
    logic signed [31:0] h_pd1 [HIST];
    int                 e_m        = 0;
    int                 credits_m  = 2;
    int                 last_acc_m = -100;
    int                 inflight_m [$];
    logic [127:0]       fifo_m [$];
    logic               sat_m      = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, e_m);
        end
    endtask

    task automatic conv(input longint v, output logic [31:0] r);
`ifdef SYSTOLIC_ACC_SAT_EN
        if (v > 64'sd2147483647) begin
            r = 32'h7FFF_FFFF;
            sat_m = 1'b1;
        end else if (v < -64'sd2147483648) begin
            r = 32'h8000_0000;
            sat_m = 1'b1;
        end else begin
            r = 32'(v);
        end
`else
        r = 32'(v);
`endif
    endtask

    task automatic model_edge(input logic b, input logic r, input logic rs,
                              input logic [31:0] p0, input logic [31:0] p1,
                              input logic [31:0] d0, input logic [31:0] d1);
        logic        sr, acc, pop;
        longint      s1, s2, s3, s4;
        logic [31:0] w1, w2, w3, w4;
        int          s;
        h_pr0[e_m % HIST] = p0;
        h_pr1[e_m % HIST] = p1;
        h_pd0[e_m % HIST] = d0;
        h_pd1[e_m % HIST] = d1;
        if (!rs) begin
            credits_m  = 2;
            last_acc_m = e_m - 100;
            inflight_m.delete();
            fifo_m.delete();
            sat_m      = 1'b0;
        end else begin
            sr  = (credits_m != 0) && (e_m - last_acc_m >= 3);
            acc = b && sr;
            pop = (fifo_m.size() > 0) && r;
            if (pop) void'(fifo_m.pop_front());
            if (inflight_m.size() > 0 && inflight_m[0] + 5 == e_m) begin
                s  = inflight_m.pop_front();
                s1 = longint'(h_pr0[(s+2) % HIST]) + longint'(h_pr0[(s+3) % HIST]);
                s2 = longint'(h_pr1[(s+3) % HIST]) + longint'(h_pr1[(s+4) % HIST]);
                s3 = longint'(h_pd0[(s+3) % HIST]) + longint'(h_pr0[(s+4) % HIST]);
                s4 = longint'(h_pd1[(s+4) % HIST]) + longint'(h_pr1[(s+5) % HIST]);
                conv(s1, w1);
                conv(s2, w2);
                conv(s3, w3);
                conv(s4, w4);
                fifo_m.push_back({w1, w2, w3, w4});
            end
            credits_m = credits_m + (pop ? 1 : 0) - (acc ? 1 : 0);
            if (acc) begin
                inflight_m.push_back(e_m);
                last_acc_m = e_m;
            end
        end
        e_m++;
    endtask

    task automatic check_outputs();
        logic [127:0] hd;
        logic         exp_sr;
        exp_sr = (credits_m != 0) && (e_m - last_acc_m >= 3);
        check_val("acc_valid", 32'(acc_valid), 32'(fifo_m.size() > 0));
        check_val("start_ready", 32'(start_ready), 32'(exp_sr));
        check_val("busy", 32'(busy), 32'(inflight_m.size() > 0));
        check_val("sat_flag", 32'(sat_flag), 32'(sat_m));
        if (fifo_m.size() > 0) begin
            hd = fifo_m[0];
            check_val("acc_1", acc_1, hd[127:96]);
            check_val("acc_2", acc_2, hd[95:64]);
            check_val("acc_3", acc_3, hd[63:32]);
            check_val("acc_4", acc_4, hd[31:0]);
        end
    endtask

    // One clock: drive inputs in the low phase, advance model, sample at the falling edge.
    task automatic tick(input logic b, input logic r, input logic rs,
                        input logic [31:0] p0, input logic [31:0] p1,
                        input logic [31:0] d0, input logic [31:0] d1);
        blk_start = b;
        acc_ready = r;
        rst_n     = rs;
        out_pr_0  = p0;
        out_pr_1  = p1;
        out_pd_0  = d0;
        out_pd_1  = d1;
        model_edge(b, r, rs, p0, p1, d0, d1);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic [31:0] rnd();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(0, 3) != 0) v = {{12{v[19]}}, v[19:0]};
        return v;
    endfunction

    task automatic scen_single();
        tick(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
        tick(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
        tick(1'b0, 1'b0, 1'b1, 32'h0001_0000, 32'h0, 32'h0, 32'h0);
        tick(1'b0, 1'b0, 1'b1, 32'h0000_4000, 32'h0002_0000, 32'hFFFF_0000, 32'h0);
        tick(1'b0, 1'b0, 1'b1, 32'hFFFF_C000, 32'h0000_8000, 32'h0, 32'h0003_0000);
        tick(1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_8000, 32'h0, 32'h0);
        check_val("s1_valid", 32'(acc_valid), 32'd1);
        check_val("s1_acc_1", acc_1, 32'h0001_4000);
        check_val("s1_acc_2", acc_2, 32'h0002_8000);
        check_val("s1_acc_3", acc_3, 32'hFFFE_C000);
        check_val("s1_acc_4", acc_4, 32'h0002_8000);
        check_val("s1_busy", 32'(busy), 32'd0);
        tick(1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
        check_val("s1_popped", 32'(acc_valid), 32'd0);
    endtask

    initial begin
        int thr;
        blk_start = 1'b0;
        acc_ready = 1'b0;
        rst_n     = 1'b0;
        out_pr_0  = '0;
        out_pr_1  = '0;
        out_pd_0  = '0;
        out_pd_1  = '0;

        tick(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        check_val("rst_start_ready", 32'(start_ready), 32'd1);
        check_val("rst_acc_valid", 32'(acc_valid), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_sat", 32'(sat_flag), 32'd0);
        check_val("rst_acc_1", acc_1, 32'd0);
        check_val("rst_acc_4", acc_4, 32'd0);

        scen_single();

        // Starts at e1 and e2 must be refused, the one at e3 accepted.
        tick(1'b1, 1'b1, 1'b1, rnd(), rnd(), rnd(), rnd());
        check_val("per_sr_e0", 32'(start_ready), 32'd0);
        tick(1'b1, 1'b1, 1'b1, rnd(), rnd(), rnd(), rnd());
        tick(1'b1, 1'b1, 1'b1, rnd(), rnd(), rnd(), rnd());
        check_val("per_sr_e2", 32'(start_ready), 32'd1);
        tick(1'b1, 1'b1, 1'b1, rnd(), rnd(), rnd(), rnd());
        check_val("per_sr_e3", 32'(start_ready), 32'd0);
        repeat (10) tick(1'b0, 1'b1, 1'b1, rnd(), rnd(), rnd(), rnd());

        // Reset at e4 discards the step.
        tick(1'b1, 1'b1, 1'b1, rnd(), rnd(), rnd(), rnd());
        repeat (3) tick(1'b0, 1'b1, 1'b1, rnd(), rnd(), rnd(), rnd());
        tick(1'b0, 1'b1, 1'b0, rnd(), rnd(), rnd(), rnd());
        repeat (4) begin
            tick(1'b0, 1'b1, 1'b1, rnd(), rnd(), rnd(), rnd());
            check_val("rst_mid_no_valid", 32'(acc_valid), 32'd0);
        end
        scen_single();

        thr = 100;
        for (int i = 0; i < 2400; i++) begin
            if (i % 200 == 0) thr = (i / 200) % 3 == 0 ? 100 : ((i / 200) % 3 == 1 ? 50 : 10);
            tick($urandom_range(0, 9) < 6, $urandom_range(0, 99) < thr, $urandom_range(0, 299) != 0,
                 rnd(), rnd(), rnd(), rnd());
        end

        // Saturation on a1.
        tick(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
        tick(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
        tick(1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'h0, 32'h0, 32'h0);
        tick(1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'h0, 32'h0, 32'h0);
        tick(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
        tick(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
`ifdef SYSTOLIC_ACC_SAT_EN
        check_val("sat_acc_1", acc_1, 32'h7FFF_FFFF);
        check_val("sat_flag_set", 32'(sat_flag), 32'd1);
`else
        check_val("wrap_acc_1", acc_1, 32'hFFFF_FFFE);
        check_val("wrap_sat_flag", 32'(sat_flag), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_2x2_force_accumulator.md
# systolic_2x2_force_accumulator

Downstream consumer of the `systolic_2x2` array for the 4-body, 2x2-tiled force pass. Samples the array's right/down partial outputs on a fixed schedule and folds them into per-body acceleration sums, applying the diagonal trick. Retires each timestep as a 4-body acceleration vector over a valid/ready handshake to the Verlet integration stage. Throttles the upstream tile scheduler through `start_ready`.

## Interface
- `DATA_W`, 32: signed fixed-point width (Q16.16) of the array outputs and the result words.
- `ACC_W`, `DATA_W+2`: internal accumulator width.
- `clk` in 1: the single clock. All state updates on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `blk_start` in 1: the tile scheduler is presenting block-0 inputs to the array this cycle.
- `start_ready` out 1: the block can accept `blk_start`.
- `out_pr_0`, `out_pr_1`, `out_pd_0`, `out_pd_1` in `DATA_W` signed: array right and down outputs.
- `acc_valid` out 1: result vector available.
- `acc_ready` in 1: integration stage consumes the vector.
- `acc_1`..`acc_4` out `DATA_W` signed: per-body acceleration sums.
- `sat_flag` out 1: sticky saturation indicator.
- `busy` out 1: at least one timestep is in flight.

## Operation
- A start is accepted when `blk_start && start_ready` at an edge. That edge is edge 0 of the step.
- Each accepted start injects a token into a 6-stage shift register. A stage's action fires at the edge where the token occupies it.
- Edge 2: `a1 = pr0`. The load clears the previous value.
- Edge 3:
  - `a1 += pr0`; a1 is final.
  - `a2 = pr1`.
  - `a3 = pd0`.
- Edge 4:
  - `a2 += pr1`; a2 is final.
  - `a3 += pr0`; a3 is final.
  - `a4 = pd1`.
- Edge 5: push `{a1, a2, a3, a4+pr1}` into the output FIFO. a4 is final on the same edge.
- Array ports not named for an edge are ignored.
- Overlap: edge 5 of step k is edge 2 of step k+1. The push captures old `a1` before the new load overwrites it. The old `a4` and the new `a1` use distinct registers and sources.
- Credits:
  - The counter resets to 2. It decrements on an accepted start and increments on an `acc_valid && acc_ready` pop.
  - When both happen on the same edge, the count is unchanged.
- `start_ready` = credits ≠ 0 AND no start accepted at either of the last two edges (minimum start period is 3).
- Arithmetic:
  - Sums are computed in `ACC_W` bits with sign extension.
  - Conversion to `DATA_W` at the push is controlled by `SYSTOLIC_ACC_SAT_EN`.
- `busy` is high while any token is in stages 0..5.

## Timing
- Reset values:
  - `start_ready`=1, `acc_valid`=0, `acc_1..4`=0, `sat_flag`=0, `busy`=0.
  - Credits = 2; FIFO empty; tokens cleared; accumulators = 0.
- Latency: `acc_valid` is high in the cycle after edge 5.
- Sustained throughput: one step per 3 cycles while `acc_ready` stays high.
- The FIFO is 2 entries, so credits guarantee it never overflows.
- `acc_1..4` hold the FIFO head and remain stable while `acc_valid && !acc_ready`.
- Pop and push on the same edge are both performed.
- Reset mid-step:
  - Discards all in-flight steps and FIFO contents.
  - No `acc_valid` is produced for discarded steps.
- `blk_start` while `start_ready`=0 is ignored, with no side effect.

## Configuration
- `SYSTOLIC_ACC_SAT_EN` defined:
  - Each `ACC_W` sum is clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1] when pushed.
  - Any clamp sets `sat_flag`, which stays set until reset.
- `SYSTOLIC_ACC_SAT_EN` undefined:
  - The low `DATA_W` bits are taken (wrap).
  - `sat_flag` is tied to 0.

## Structure
- Package `systolic_nbody_pkg`:
  - `DATA_W` and `ACC_W` defaults.
  - `N_BODIES`=4.
  - Schedule-edge constants (2..5).
  - Credit depth 2.
  - Typedef `acc_vec_t` (four `DATA_W` words).
- One sub-module, `acc_vec_fifo`: a 2-entry FIFO of `acc_vec_t` with push, pop, and valid outputs.

## Test plan
- Single step, start at edge 0:
  - Stimulus:
    - e2: pr0=1.0.
    - e3: pr0=0.25, pr1=2.0, pd0=-1.0.
    - e4: pr1=0.5, pr0=-0.25, pd1=3.0.
    - e5: pr1=-0.5.
  - Response: `acc_valid` high after e5 with 1.25 / 2.5 / -1.25 / 2.5; `busy` low after e5.
- Back-to-back starts at e0 and e3 with `acc_ready`=1 -> two vectors after e5 and e8, each matching its own stimulus. There is no crosstalk at the shared e5.
- `acc_ready`=0, starts at e0 and e3:
  - `start_ready` low from e4; a `blk_start` at e6 is ignored.
  - `acc_ready`=1 at e10 -> `start_ready` high after e10.
- Saturation, pr0=0x7FFF_FFFF at e2 and e3:
  - With the macro: `acc_1`=0x7FFF_FFFF and `sat_flag`=1.
  - Without the macro: `acc_1`=0xFFFF_FFFE and `sat_flag`=0.
- `rst_n` low at e4 of a step -> no `acc_valid` and all outputs at reset values; a fresh step afterwards matches scenario 1.
- Start presented at e1 and e2 after an accepted start -> ignored (`start_ready`=0); accepted at e3.
